// File: rtl/ex_mem_stage_pkg.sv
// ============================================================================
// Module      : ex_mem_stage_pkg
// Description : Shared MIPS datapath constants, ALU encodings and the
//               MEM/WB control bundle carried through the EX/MEM register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ex_mem_stage_pkg;

    localparam int c_DATA_W = 32;
    localparam int c_REG_W  = 5;

    localparam logic [c_REG_W-1:0] c_REG_ZERO = '0;

    // ALU control encodings produced by the upstream ALU decoder
    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_ctrl_e;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } mem_ctrl_t;

    localparam mem_ctrl_t c_CTRL_NONE = '{default: 1'b0};

endpackage : ex_mem_stage_pkg

`default_nettype wire

// File: rtl/ex_mem_stage_if.sv
// ============================================================================
// Module      : ex_mem_stage_if
// Description : EX-side inputs and MEM-side/forwarding outputs of the EX/MEM
//               pipeline register. The stage itself uses the slave modport.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ex_mem_stage_if
    import ex_mem_stage_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int REG_W  = c_REG_W
);

    logic              ex_valid;
    logic [DATA_W-1:0] ex_alu_out;
    logic              ex_zero;
    logic [DATA_W-1:0] ex_write_data;
    logic [REG_W-1:0]  ex_rd;
    logic [DATA_W-1:0] ex_branch_target;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              ex_mem_to_reg;
    logic              ex_branch;
    logic              ex_branch_ne;

    logic              mem_valid;
    logic [DATA_W-1:0] mem_alu_out;
    logic [DATA_W-1:0] mem_write_data;
    logic [REG_W-1:0]  mem_rd;
    logic              mem_reg_write;
    logic              mem_mem_read;
    logic              mem_mem_write;
    logic              mem_mem_to_reg;
    logic              pc_src;
    logic [DATA_W-1:0] branch_target;
    logic              fwd_valid;
    logic [REG_W-1:0]  fwd_rd;
    logic [DATA_W-1:0] fwd_data;
    logic              fwd_is_load;

    modport master (
        output ex_valid, ex_alu_out, ex_zero, ex_write_data, ex_rd,
               ex_branch_target, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_mem_to_reg, ex_branch, ex_branch_ne,
        input  mem_valid, mem_alu_out, mem_write_data, mem_rd,
               mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg,
               pc_src, branch_target, fwd_valid, fwd_rd, fwd_data, fwd_is_load
    );

    modport slave (
        input  ex_valid, ex_alu_out, ex_zero, ex_write_data, ex_rd,
               ex_branch_target, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_mem_to_reg, ex_branch, ex_branch_ne,
        output mem_valid, mem_alu_out, mem_write_data, mem_rd,
               mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg,
               pc_src, branch_target, fwd_valid, fwd_rd, fwd_data, fwd_is_load
    );

endinterface : ex_mem_stage_if

`default_nettype wire

// File: rtl/ex_mem_stage_branch_resolve.sv
// ============================================================================
// Module      : branch_resolve
// Description : Conditional branch decision from the ALU zero flag; shared
//               with the fetch unit so both agree on taken/not-taken.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolve (
    input  wire logic valid,
    input  wire logic branch,
    input  wire logic branch_ne,
    input  wire logic zero,
    output logic      taken
);

    assign taken = valid & branch & (zero ^ branch_ne);

endmodule : branch_resolve

`default_nettype wire

// File: rtl/ex_mem_stage.sv
// ============================================================================
// Module      : ex_mem_stage
// Description : EX/MEM pipeline register with branch resolution, one-shot
//               wrong-path squash and MEM-stage forwarding outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int REG_W  = c_REG_W
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    input  wire logic     stall,
    input  wire logic     flush,
    ex_mem_stage_if.slave bus
);

    logic              w_taken;
    mem_ctrl_t         w_ex_ctrl;
    logic              w_rd_nonzero;

    logic              r_valid;
    mem_ctrl_t         r_ctrl;
    logic              r_pc_src;
    logic [DATA_W-1:0] r_alu_out;
    logic [DATA_W-1:0] r_write_data;
    logic [REG_W-1:0]  r_rd;
    logic [DATA_W-1:0] r_branch_target;

    branch_resolve u_branch_resolve (
        .valid     (bus.ex_valid),
        .branch    (bus.ex_branch),
        .branch_ne (bus.ex_branch_ne),
        .zero      (bus.ex_zero),
        .taken     (w_taken)
    );

    assign w_ex_ctrl = '{reg_write:  bus.ex_reg_write,
                         mem_read:   bus.ex_mem_read,
                         mem_write:  bus.ex_mem_write,
                         mem_to_reg: bus.ex_mem_to_reg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid         <= 1'b0;
            r_ctrl          <= c_CTRL_NONE;
            r_pc_src        <= 1'b0;
            r_alu_out       <= '0;
            r_write_data    <= '0;
            r_rd            <= '0;
            r_branch_target <= '0;
        end else if (flush) begin
            r_valid         <= 1'b0;
            r_ctrl          <= c_CTRL_NONE;
            r_pc_src        <= 1'b0;
            r_alu_out       <= '0;
            r_write_data    <= '0;
            r_rd            <= '0;
            r_branch_target <= '0;
        end else if (!stall) begin
            r_alu_out       <= bus.ex_alu_out;
            r_write_data    <= bus.ex_write_data;
            r_rd            <= bus.ex_rd;
            r_branch_target <= bus.ex_branch_target;
            // A taken branch in this stage means EX holds the wrong-path
            // instruction; the squash never re-arms, so it is one-shot.
            if (r_pc_src) begin
                r_valid  <= 1'b0;
                r_ctrl   <= c_CTRL_NONE;
                r_pc_src <= 1'b0;
            end else begin
                r_valid  <= bus.ex_valid;
                r_ctrl   <= bus.ex_valid ? w_ex_ctrl : c_CTRL_NONE;
                r_pc_src <= w_taken;
            end
        end
    end

    assign bus.mem_valid      = r_valid;
    assign bus.mem_alu_out    = r_alu_out;
    assign bus.mem_write_data = r_write_data;
    assign bus.mem_rd         = r_rd;
    assign bus.mem_reg_write  = r_valid & r_ctrl.reg_write;
    assign bus.mem_mem_read   = r_valid & r_ctrl.mem_read;
    assign bus.mem_mem_write  = r_valid & r_ctrl.mem_write;
    assign bus.mem_mem_to_reg = r_valid & r_ctrl.mem_to_reg;
    assign bus.pc_src         = r_valid & r_pc_src;
    assign bus.branch_target  = r_branch_target;

    // Forwarding depends on registered state only; stores never forward.
    assign w_rd_nonzero    = (r_rd != c_REG_ZERO);
    assign bus.fwd_valid   = r_valid & r_ctrl.reg_write & ~r_ctrl.mem_read
                           & ~r_ctrl.mem_write & w_rd_nonzero;
    assign bus.fwd_rd      = r_rd;
    assign bus.fwd_data    = r_alu_out;
    assign bus.fwd_is_load = r_valid & r_ctrl.mem_read & w_rd_nonzero;

endmodule : ex_mem_stage

`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
// ============================================================================
// Module      : tb_ex_mem_stage
// Description : Directed self-checking bench for the EX/MEM pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_mem_stage;
    import ex_mem_stage_pkg::*;

    logic clk;
    logic rst_n;
    logic stall;
    logic flush;

    int   n_total;
    int   n_bad;

    ex_mem_stage_if bus ();

    ex_mem_stage u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .stall (stall),
        .flush (flush),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_ex(input logic v, input logic [31:0] alu, input logic z,
                            input logic [31:0] wd, input logic [4:0] rd,
                            input logic [31:0] tgt, input logic rw, input logic mr,
                            input logic mw, input logic m2r, input logic br,
                            input logic bne);
        bus.ex_valid         = v;
        bus.ex_alu_out       = alu;
        bus.ex_zero          = z;
        bus.ex_write_data    = wd;
        bus.ex_rd            = rd;
        bus.ex_branch_target = tgt;
        bus.ex_reg_write     = rw;
        bus.ex_mem_read      = mr;
        bus.ex_mem_write     = mw;
        bus.ex_mem_to_reg    = m2r;
        bus.ex_branch        = br;
        bus.ex_branch_ne     = bne;
    endtask

    // One active edge, then settle on the falling edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        stall   = 1'b0;
        flush   = 1'b0;
        rst_n   = 1'b0;
        drive_ex(1, 32'hFFFF_FFFF, 1, 32'hABCD_0000, 5'd7, 32'h0040_0020, 1, 1, 1, 1, 1, 0);
        step();
        step();
        check_val("rst_valid",   64'(bus.mem_valid),     64'd0);
        check_val("rst_alu",     64'(bus.mem_alu_out),   64'd0);
        check_val("rst_pcsrc",   64'(bus.pc_src),        64'd0);
        check_val("rst_target",  64'(bus.branch_target), 64'd0);
        check_val("rst_fwd",     64'(bus.fwd_valid),     64'd0);
        check_val("rst_isload",  64'(bus.fwd_is_load),   64'd0);
        check_val("rst_memwr",   64'(bus.mem_mem_write), 64'd0);

        // add r3 = 7
        drive_ex(1, 32'h0000_0007, 0, 32'h0, 5'd3, 32'h0, 1, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        step();
        check_val("add_alu",     64'(bus.mem_alu_out),   64'd7);
        check_val("add_fwdv",    64'(bus.fwd_valid),     64'd1);
        check_val("add_fwdrd",   64'(bus.fwd_rd),        64'd3);
        check_val("add_fwddata", 64'(bus.fwd_data),      64'd7);

        // taken beq then a wrong-path add
        drive_ex(1, 32'h0, 1, 32'h0, 5'd0, 32'h0040_0020, 0, 0, 0, 0, 1, 0);
        step();
        check_val("beq_pcsrc",   64'(bus.pc_src),        64'd1);
        check_val("beq_target",  64'(bus.branch_target), 64'h0040_0020);
        check_val("beq_fwdv",    64'(bus.fwd_valid),     64'd0);
        drive_ex(1, 32'h0000_0011, 0, 32'h0, 5'd4, 32'h0, 1, 0, 0, 0, 0, 0);
        step();
        check_val("sq_valid",    64'(bus.mem_valid),     64'd0);
        check_val("sq_pcsrc",    64'(bus.pc_src),        64'd0);
        check_val("sq_rw",       64'(bus.mem_reg_write), 64'd0);
        check_val("sq_fwdv",     64'(bus.fwd_valid),     64'd0);

        // bne with equal operands is not taken
        drive_ex(1, 32'h0, 1, 32'h0, 5'd0, 32'h0040_0080, 0, 0, 0, 0, 1, 1);
        step();
        check_val("bne_pcsrc",   64'(bus.pc_src),        64'd0);
        check_val("bne_valid",   64'(bus.mem_valid),     64'd1);
        drive_ex(1, 32'h0000_0022, 0, 32'h0, 5'd6, 32'h0, 1, 0, 0, 0, 0, 0);
        step();
        check_val("bnx_valid",   64'(bus.mem_valid),     64'd1);
        check_val("bnx_fwdrd",   64'(bus.fwd_rd),        64'd6);
        check_val("bnx_fwddata", 64'(bus.fwd_data),      64'h22);

        // taken beq held by a 3-cycle stall, squash deferred to release
        drive_ex(1, 32'h0, 1, 32'h0, 5'd0, 32'h0040_0100, 0, 0, 0, 0, 1, 0);
        step();
        check_val("bst_pcsrc",   64'(bus.pc_src),        64'd1);
        drive_ex(1, 32'h0000_0033, 0, 32'h0, 5'd7, 32'h0, 1, 0, 0, 0, 0, 0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("stl_pcsrc",  64'(bus.pc_src),        64'd1);
            check_val("stl_target", 64'(bus.branch_target), 64'h0040_0100);
            check_val("stl_valid",  64'(bus.mem_valid),     64'd1);
            check_val("stl_alu",    64'(bus.mem_alu_out),   64'd0);
        end
        stall = 1'b0;
        step();
        check_val("rel_valid",   64'(bus.mem_valid),     64'd0);
        check_val("rel_pcsrc",   64'(bus.pc_src),        64'd0);
        check_val("rel_fwdv",    64'(bus.fwd_valid),     64'd0);
        step();
        check_val("rel2_valid",  64'(bus.mem_valid),     64'd1);
        check_val("rel2_fwdrd",  64'(bus.fwd_rd),        64'd7);

        // lw r5
        drive_ex(1, 32'h0000_1000, 0, 32'h0, 5'd5, 32'h0, 1, 1, 0, 1, 0, 0);
        step();
        check_val("lw_isload",   64'(bus.fwd_is_load),    64'd1);
        check_val("lw_fwdv",     64'(bus.fwd_valid),      64'd0);
        check_val("lw_m2r",      64'(bus.mem_mem_to_reg), 64'd1);
        check_val("lw_mr",       64'(bus.mem_mem_read),   64'd1);
        // write to r0
        drive_ex(1, 32'h0000_0044, 0, 32'h0, 5'd0, 32'h0, 1, 0, 0, 0, 0, 0);
        step();
        check_val("r0_fwdv",     64'(bus.fwd_valid),     64'd0);
        check_val("r0_valid",    64'(bus.mem_valid),     64'd1);
        check_val("r0_rw",       64'(bus.mem_reg_write), 64'd1);
        // sw with reg_write wrongly set still must not forward
        drive_ex(1, 32'h0000_2000, 0, 32'h0000_DEAD, 5'd9, 32'h0, 1, 0, 1, 0, 0, 0);
        step();
        check_val("sw_memwr",    64'(bus.mem_mem_write),  64'd1);
        check_val("sw_fwdv",     64'(bus.fwd_valid),      64'd0);
        check_val("sw_wdata",    64'(bus.mem_write_data), 64'h0000_DEAD);
        check_val("sw_isload",   64'(bus.fwd_is_load),    64'd0);

        // flush beats stall
        drive_ex(1, 32'h0000_0055, 0, 32'h0, 5'd8, 32'h0, 1, 0, 0, 0, 0, 0);
        flush = 1'b1;
        stall = 1'b1;
        step();
        check_val("fs_valid",    64'(bus.mem_valid),     64'd0);
        check_val("fs_rw",       64'(bus.mem_reg_write), 64'd0);
        check_val("fs_memwr",    64'(bus.mem_mem_write), 64'd0);
        check_val("fs_alu",      64'(bus.mem_alu_out),   64'd0);
        check_val("fs_fwdv",     64'(bus.fwd_valid),     64'd0);
        flush = 1'b0;
        stall = 1'b0;

        // flush with a pending squash
        drive_ex(1, 32'h0, 0, 32'h0, 5'd0, 32'h0040_0200, 0, 0, 0, 0, 1, 1);
        step();
        check_val("fp_pcsrc0",   64'(bus.pc_src),        64'd1);
        drive_ex(1, 32'h0000_0066, 0, 32'h0, 5'd2, 32'h0, 1, 0, 0, 0, 0, 0);
        flush = 1'b1;
        step();
        check_val("fp_pcsrc",    64'(bus.pc_src),        64'd0);
        check_val("fp_valid",    64'(bus.mem_valid),     64'd0);
        flush = 1'b0;
        step();
        check_val("fp_next",     64'(bus.mem_valid),     64'd1);

        // asynchronous reset mid-cycle
        drive_ex(1, 32'h0000_0077, 0, 32'h0, 5'd3, 32'h0, 1, 0, 0, 0, 0, 0);
        step();
        check_val("ar_pre",      64'(bus.fwd_valid),     64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("ar_valid",    64'(bus.mem_valid),     64'd0);
        check_val("ar_alu",      64'(bus.mem_alu_out),   64'd0);
        check_val("ar_fwdv",     64'(bus.fwd_valid),     64'd0);
        check_val("ar_fwdrd",    64'(bus.fwd_rd),        64'd0);

        // reset during stall with pending squash discards it
        @(negedge clk);
        rst_n = 1'b1;
        drive_ex(1, 32'h0, 1, 32'h0, 5'd0, 32'h0040_0300, 0, 0, 0, 0, 1, 0);
        step();
        check_val("rs_pcsrc",    64'(bus.pc_src),        64'd1);
        stall = 1'b1;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        stall = 1'b0;
        drive_ex(1, 32'h0000_0088, 0, 32'h0, 5'd10, 32'h0, 1, 0, 0, 0, 0, 0);
        step();
        check_val("rs_valid",    64'(bus.mem_valid),     64'd1);
        check_val("rs_fwdrd",    64'(bus.fwd_rd),        64'd10);
        check_val("rs_pcsrc2",   64'(bus.pc_src),        64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_ex_mem_stage

`default_nettype wire
